// File: rtl/mem_loader.sv
// Byte-stream memory loader: parses an address/count header, then assembles
// 16-bit words from byte pairs and writes them out through a single write port.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for ADDR_HI
// ADDR_LO | waiting for ADDR_LO
// CNT_HI  | waiting for CNT_HI
// CNT_LO  | waiting for CNT_LO
// CHECK   | one-cycle range check of start+count against lines
// DATA_HI | waiting for the high byte of a data word
// DATA_LO | waiting for the low byte of a data word
// WRITE   | one-cycle write strobe
// DONE    | one-cycle done pulse
module mem_loader #(
    parameter int dtype    = 16,
    parameter int lines    = 1000,
    parameter int addr_len = $clog2(lines)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                mem_write,
    output logic [addr_len-1:0] mem_addr,
    output logic [dtype-1:0]    mem_data,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        CHECK,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE
    } state_t;

    state_t              state, next_state;
    logic [15:0]         start_r;
    logic [15:0]         count_r;
    logic [15:0]         remaining;
    logic [7:0]          hi_byte;
    logic [addr_len-1:0] waddr;
    logic [16:0]         frame_end;
    logic                over_range;
    logic                ready_state;
    logic                take;

    assign frame_end  = {1'b0, start_r} + {1'b0, count_r};
    assign over_range = frame_end > 17'(lines);

    always_comb begin
        ready_state = 1'b0;
        case (state)
            IDLE, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO: ready_state = 1'b1;
            default:                                         ready_state = 1'b0;
        endcase
    end

    // Gated by reset so no byte is ever consumed while reset is held.
    assign rx_ready  = ready_state && !reset;
    assign take      = rx_valid && rx_ready;
    assign mem_write = (state == WRITE) && !reset;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (take) next_state = ADDR_LO;
            ADDR_LO: if (take) next_state = CNT_HI;
            CNT_HI:  if (take) next_state = CNT_LO;
            CNT_LO:  if (take) next_state = CHECK;
            CHECK: begin
                if (over_range)          next_state = IDLE;
                else if (count_r == 16'd0) next_state = DONE;
                else                     next_state = DATA_HI;
            end
            DATA_HI: if (take) next_state = DATA_LO;
            DATA_LO: if (take) next_state = WRITE;
            WRITE:   next_state = (remaining == 16'd1) ? DONE : DATA_HI;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            start_r   <= '0;
            count_r   <= '0;
            remaining <= '0;
            hi_byte   <= '0;
            waddr     <= '0;
            mem_addr  <= '0;
            mem_data  <= '0;
            error     <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (take) begin
                    start_r[15:8] <= rx_data;
                    error         <= 1'b0;
                end
                ADDR_LO: if (take) start_r[7:0]  <= rx_data;
                CNT_HI:  if (take) count_r[15:8] <= rx_data;
                CNT_LO:  if (take) count_r[7:0]  <= rx_data;
                CHECK: begin
                    waddr     <= start_r[addr_len-1:0];
                    remaining <= count_r;
                    if (over_range) error <= 1'b1;
                end
                DATA_HI: if (take) hi_byte <= rx_data;
                // Address and data are captured here so they stay put between strobes.
                DATA_LO: if (take) begin
                    mem_data <= dtype'({hi_byte, rx_data});
                    mem_addr <= waddr;
                end
                WRITE: begin
                    waddr     <= waddr + addr_len'(1);
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader: header parsing, word writes, range
// rejection, gated input and mid-frame reset.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_write;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        busy;
    logic        done;
    logic        error;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [9:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    int          wq_cyc[$];
    int          done_cyc[$];
    int          bfall_cyc[$];
    logic        prev_busy = 1'b0;
    int          acc_at[8];

    mem_loader dut (
        .clock    (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_write) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_data);
            wq_cyc.push_back(cyc);
            vectors++;
            if (rx_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL ready_in_write: rx_ready=%b required 0", rx_ready);
            end
        end
        if (done) begin
            done_cyc.push_back(cyc);
            vectors++;
            if (error !== 1'b0 || rx_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL done_cycle: error=%b rx_ready=%b required 0/0", error, rx_ready);
            end
        end
        if (prev_busy && !busy) bfall_cyc.push_back(cyc);
        prev_busy = busy;
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        done_cyc.delete();
        bfall_cyc.delete();
    endtask

    // Present one byte (after 'gap' idle cycles) and wait until it is accepted.
    task automatic send(input logic [7:0] b, input int gap, output int acc);
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        acc      = -1;
        for (int t = 0; t < 40; t++) begin
            if (rx_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (acc < 0) begin
            miscompares++;
            $display("FAIL byte_accept: byte %h not accepted within 40 cycles", b);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] f, input int n, input logic [31:0] g);
        int a;
        for (int i = 0; i < n; i++) begin
            send(f[63-8*i -: 8], int'(g[31-4*i -: 4]), a);
            acc_at[i] = a;
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_two_writes(input string name);
        vectors++;
        if (wq_addr.size() !== 2) begin
            miscompares++;
            $display("FAIL %s_write_count: got %0d required 2", name, wq_addr.size());
        end else begin
            vectors++;
            if (wq_addr[0] !== 10'd16 || wq_data[0] !== 16'hABCD) begin
                miscompares++;
                $display("FAIL %s_write0: got %h@%0d required abcd@16", name, wq_data[0], wq_addr[0]);
            end
            vectors++;
            if (wq_addr[1] !== 10'd17 || wq_data[1] !== 16'h1234) begin
                miscompares++;
                $display("FAIL %s_write1: got %h@%0d required 1234@17", name, wq_data[1], wq_addr[1]);
            end
            vectors++;
            if (wq_cyc[0] !== acc_at[5] || wq_cyc[1] !== acc_at[7]) begin
                miscompares++;
                $display("FAIL %s_write_latency: got cycles %0d,%0d required %0d,%0d",
                         name, wq_cyc[0], wq_cyc[1], acc_at[5], acc_at[7]);
            end
            vectors++;
            if (done_cyc.size() !== 1 || (done_cyc.size() == 1 && done_cyc[0] !== wq_cyc[1] + 1)) begin
                miscompares++;
                $display("FAIL %s_done: got %0d pulses required 1 at cycle %0d", name, done_cyc.size(), wq_cyc[1] + 1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_ready, mem_write, busy, done, error} !== 5'b0 || mem_addr !== 10'd0 || mem_data !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b wr=%b busy=%b done=%b err=%b addr=%0d data=%h required all 0",
                     rx_ready, mem_write, busy, done, error, mem_addr, mem_data);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: rx_ready=%b busy=%b required 1/0", rx_ready, busy);
        end
    endtask

    task automatic test_basic();
        clear_log();
        send_frame(64'h0010_0002_ABCD_1234, 8, 32'h0);
        repeat (8) @(negedge clk);
        check_two_writes("basic");
        vectors++;
        if (done_cyc.size() != 1 || bfall_cyc.size() != 1 || bfall_cyc[0] !== done_cyc[0] + 1) begin
            miscompares++;
            $display("FAIL basic_busy_fall: got %0d falls required 1 right after done", bfall_cyc.size());
        end
        vectors++;
        if (mem_addr !== 10'd17 || mem_data !== 16'h1234 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_hold: addr=%0d data=%h err=%b required 17 1234 0", mem_addr, mem_data, error);
        end
    endtask

    task automatic test_zero_count();
        clear_log();
        send_frame(64'h0005_0000_0000_0000, 4, 32'h0);
        repeat (6) @(negedge clk);
        vectors++;
        if (wq_addr.size() !== 0) begin
            miscompares++;
            $display("FAIL zero_writes: got %0d writes required 0", wq_addr.size());
        end
        vectors++;
        if (done_cyc.size() !== 1 || (done_cyc.size() == 1 && done_cyc[0] !== acc_at[3] + 1) || error !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: got %0d pulses err=%b required 1 at cycle %0d err=0",
                     done_cyc.size(), error, acc_at[3] + 1);
        end
    endtask

    task automatic test_range_error();
        clear_log();
        send_frame(64'h03E6_0003_0000_0000, 4, 32'h0);
        repeat (6) @(negedge clk);
        vectors++;
        if (error !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL range_error: err=%b busy=%b rdy=%b required 1 0 1", error, busy, rx_ready);
        end
        vectors++;
        if (wq_addr.size() !== 0 || done_cyc.size() !== 0) begin
            miscompares++;
            $display("FAIL range_no_write: writes=%0d dones=%0d required 0 0", wq_addr.size(), done_cyc.size());
        end
    endtask

    task automatic test_boundary();
        int a;
        clear_log();
        send(8'h03, 0, a);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL error_clear: err=%b required 0 after ADDR_HI", error);
        end
        send_frame(64'hE600_0211_2233_4400, 7, 32'h0);
        repeat (8) @(negedge clk);
        vectors++;
        if (wq_addr.size() !== 2 || (wq_addr.size() == 2 &&
            (wq_addr[0] !== 10'd998 || wq_data[0] !== 16'h1122 ||
             wq_addr[1] !== 10'd999 || wq_data[1] !== 16'h3344))) begin
            miscompares++;
            $display("FAIL boundary_writes: got %0d writes required 1122@998 3344@999", wq_addr.size());
        end
        vectors++;
        if (done_cyc.size() !== 1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL boundary_done: dones=%0d err=%b required 1 0", done_cyc.size(), error);
        end
    endtask

    task automatic test_gapped();
        clear_log();
        send_frame(64'h0010_0002_ABCD_1234, 8, 32'h3021_0425);
        repeat (8) @(negedge clk);
        check_two_writes("gapped");
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_frame(64'h0010_0002_AB00_0000, 5, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_ready: rx_ready=%b required 0", rx_ready);
        end
        @(negedge clk);
        vectors++;
        if ({mem_write, busy, done, error} !== 4'b0 || mem_addr !== 10'd0 || mem_data !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid_state: wr=%b busy=%b done=%b err=%b addr=%0d data=%h required all 0",
                     mem_write, busy, done, error, mem_addr, mem_data);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (wq_addr.size() !== 0 || done_cyc.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_nowrite: writes=%0d dones=%0d required 0 0", wq_addr.size(), done_cyc.size());
        end
        send_frame(64'h0020_0001_BEEF_0000, 6, 32'h0);
        repeat (8) @(negedge clk);
        vectors++;
        if (wq_addr.size() !== 1 || (wq_addr.size() == 1 && (wq_addr[0] !== 10'd32 || wq_data[0] !== 16'hBEEF))
            || done_cyc.size() !== 1) begin
            miscompares++;
            $display("FAIL reset_mid_reload: writes=%0d dones=%0d required beef@32 and 1 done",
                     wq_addr.size(), done_cyc.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_count();
        test_range_error();
        test_boundary();
        test_gapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter dtype, default 16, memory word width; only 16 is supported.
REQ-002 Parameter lines, default 1000, memory depth in words.
REQ-003 Parameter addr_len, default $clog2(lines), memory address width.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  incoming byte.
REQ-007 rx_valid  input  1  rx_data is valid.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_write  output  1  write strobe to the memory's write port B.
REQ-010 mem_addr  output  addr_len  write address to the memory's write port B.
REQ-011 mem_data  output  dtype  write data to the memory's write port B.
REQ-012 busy  output  1  a frame is in progress.
REQ-013 done  output  1  one-cycle pulse when a frame completes.
REQ-014 error  output  1  sticky flag: the last frame was rejected as out of range.

Function
REQ-015 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1; rx_data is ignored in all other cycles.
REQ-016 A frame SHALL be: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT data words, each sent high byte first.
REQ-017 The state machine SHALL use the states IDLE, ADDR_LO, CNT_HI, CNT_LO, CHECK, DATA_HI, DATA_LO, WRITE and DONE.
- IDLE waits for and accepts ADDR_HI.
- Each header or data byte acceptance advances exactly one state.
REQ-018 rx_ready SHALL be 1 in IDLE, ADDR_LO, CNT_HI, CNT_LO, DATA_HI and DATA_LO, and 0 in CHECK, WRITE and DONE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 CHECK SHALL last exactly one cycle and evaluate start+count with 17-bit unsigned arithmetic.
- start+count > lines: error=1 and next state IDLE; no writes occur.
- Otherwise, if count==0: next state DONE.
- Otherwise: next state DATA_HI.
REQ-021 error SHALL clear to 0 when the next frame's ADDR_HI byte is accepted.
REQ-022 Word assembly SHALL be mem_data = {hi_byte, lo_byte}.
REQ-023 Acceptance of DATA_LO SHALL lead to the WRITE state in the next cycle.
- In WRITE: mem_write=1 for exactly one cycle, mem_addr = current write address.
- The write address starts at start[addr_len-1:0] and increments by 1 after each write.
REQ-024 After WRITE, the next state SHALL be DATA_HI if words remain, otherwise DONE.
REQ-025 DONE SHALL last one cycle with done=1, then the machine returns to IDLE.
REQ-026 Write latency from DATA_LO acceptance to mem_write SHALL be exactly 1 cycle; back-to-back words therefore write at most once every 3 cycles.
REQ-027 mem_addr and mem_data SHALL hold their last values when mem_write=0.
REQ-028 A frame ending exactly at lines SHALL be legal.
- Example: start=998, count=2 with lines=1000 writes addresses 998 and 999.
REQ-029 done and error SHALL never be 1 in the same cycle.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL go to IDLE with mem_write=0, mem_addr=0, mem_data=0, done=0, error=0 and busy=0.
REQ-031 rx_ready SHALL be 0 during any cycle with reset=1, and 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted mid-frame SHALL abandon the frame.
- Memory writes already issued remain.
- No further mem_write occurs.
- Bytes already consumed are not replayed.

Verification
REQ-033 Frame 00 10 00 02 AB CD 12 34 with rx_valid held high -> writes 0xABCD@16 then 0x1234@17, each a 1-cycle strobe; done pulses one cycle after the second write; busy falls with done.
REQ-034 Header 00 05 00 00 -> no mem_write; done pulses 2 cycles after CNT_LO is accepted (CHECK, then DONE); error=0.
REQ-035 Header 03 E6 00 03 (start 998, count 3) -> error=1 after CHECK, no writes, return to IDLE; error clears when the next ADDR_HI is accepted.
REQ-036 Header 03 E6 00 02 plus 4 data bytes -> writes at 998 and 999; error=0.
REQ-037 Randomly gated rx_valid, including gaps inside a data word -> the same write sequence as REQ-033; no byte is lost or duplicated; rx_ready=0 in CHECK, WRITE and DONE.
REQ-038 Reset pulsed after the first data byte of REQ-033 -> no write issued; all outputs at reset values; a fresh frame then loads correctly.
